// File: rtl/cam_pixel_packer.sv
// DVP byte stream to DDR-width word packer with start-up frame skipping,
// line/frame geometry checking, end-of-frame partial-word flush and frame markers.
module cam_pixel_packer #(
  parameter int unsigned DATA_W      = 256,
  parameter int unsigned H_ACT       = 1024,
  parameter int unsigned V_ACT       = 768,
  parameter int unsigned SKIP_FRAMES = 2,
  parameter int unsigned BYTE_SWAP   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_sof,
  output logic              frame_done,
  output logic              line_err,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned PPW = DATA_W / 16;
  localparam int unsigned SW  = $clog2(PPW);
  localparam int unsigned PW  = $clog2(H_ACT + 2);
  localparam int unsigned LW  = $clog2(V_ACT + 2);

  localparam logic [SW-1:0] SlotLast = SW'(PPW - 1);
  localparam logic [PW-1:0] PixAct   = PW'(H_ACT);
  localparam logic [PW-1:0] PixSat   = PW'(H_ACT + 1);
  localparam logic [LW-1:0] LineAct  = LW'(V_ACT);
  localparam logic [LW-1:0] LineSat  = LW'(V_ACT + 1);
  localparam logic [3:0]    SkipLast = 4'(SKIP_FRAMES - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSync   = 2'd1;
  localparam logic [1:0] StSkip   = 2'd2;
  localparam logic [1:0] StActive = 2'd3;

  logic              vs_q, hr_q, vs_prev_q, hr_prev_q;
  logic [7:0]        dat_q;
  logic              phase_q, phase_d;
  logic [7:0]        byte_q, byte_d;
  logic [1:0]        state_q, state_d;
  logic [3:0]        skip_q, skip_d;
  logic [PW-1:0]     pix_q, pix_d;
  logic [LW-1:0]     line_q, line_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic [DATA_W-1:0] acc_q, acc_d, word;
  logic              sof_pend_q, sof_pend_d;
  logic              wr_en_q, wr_en_d, wr_sof_q, wr_sof_d;
  logic              frame_done_q, frame_done_d, line_err_q, line_err_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic        hr_eff, vs_rise, hr_rise, hr_fall, pix_done, pix_keep;
  logic [15:0] pixel;

  // href seen during vertical blanking never counts as line data
  assign hr_eff   = hr_q & ~vs_q;
  assign vs_rise  = vs_q & ~vs_prev_q;
  assign hr_rise  = hr_eff & ~hr_prev_q;
  assign hr_fall  = ~hr_eff & hr_prev_q;
  assign pix_done = hr_eff & phase_q;
  assign pix_keep = (state_q == StActive) & pix_done & (pix_q < PixAct) & (line_q < LineAct);
  assign pixel    = (BYTE_SWAP != 0) ? {dat_q, byte_q} : {byte_q, dat_q};

  always_comb begin
    state_d      = state_q;
    skip_d       = skip_q;
    phase_d      = hr_eff & ~phase_q;
    byte_d       = byte_q;
    pix_d        = pix_q;
    line_d       = line_q;
    slot_d       = slot_q;
    acc_d        = acc_q;
    sof_pend_d   = sof_pend_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    wr_sof_d     = 1'b0;
    frame_done_d = 1'b0;
    line_err_d   = line_err_q;
    frame_cnt_d  = frame_cnt_q;
    word         = acc_q;
    word[{slot_q, 4'b0000} +: 16] = pixel;
    if (hr_eff && !phase_q) byte_d = dat_q;

    case (state_q)
      StIdle: if (en) state_d = StSync;
      StSync: begin
        if (!en) begin
          state_d = StIdle;
        end else if (vs_rise) begin
          sof_pend_d = 1'b1;
          skip_d     = '0;
          state_d    = (SKIP_FRAMES == 0) ? StActive : StSkip;
        end
      end
      StSkip: begin
        if (!en) begin
          state_d = StIdle;
        end else if (vs_rise) begin
          if (skip_q == SkipLast) state_d = StActive;
          else skip_d = skip_q + 4'd1;
        end
      end
      StActive: begin
        if (hr_rise) pix_d = '0;
        else if (pix_done && pix_q != PixSat) pix_d = pix_q + 1'b1;
        if (hr_fall) begin
          if (pix_q != PixAct) line_err_d = 1'b1;
          if (line_q != LineSat) line_d = line_q + 1'b1;
        end
        if (pix_keep) begin
          if (slot_q == SlotLast) begin
            wr_en_d    = 1'b1;
            wr_data_d  = word;
            wr_sof_d   = sof_pend_q;
            sof_pend_d = 1'b0;
            acc_d      = '0;
            slot_d     = '0;
          end else begin
            acc_d  = word;
            slot_d = slot_q + 1'b1;
          end
        end
        // Frame boundary: flush partial word (unused slots already zero), then rearm
        if (vs_rise) begin
          if (slot_q != '0) begin
            wr_en_d   = 1'b1;
            wr_data_d = acc_q;
            wr_sof_d  = sof_pend_q;
          end
          if (line_q != LineAct) line_err_d = 1'b1;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          sof_pend_d   = 1'b1;
          line_d       = '0;
          pix_d        = '0;
          slot_d       = '0;
          acc_d        = '0;
          if (!en) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StActive) begin
      pix_d  = '0;
      line_d = '0;
      slot_d = '0;
      acc_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q         <= 1'b0;
      hr_q         <= 1'b0;
      dat_q        <= '0;
      vs_prev_q    <= 1'b0;
      hr_prev_q    <= 1'b0;
      phase_q      <= 1'b0;
      byte_q       <= '0;
      state_q      <= StIdle;
      skip_q       <= '0;
      pix_q        <= '0;
      line_q       <= '0;
      slot_q       <= '0;
      acc_q        <= '0;
      sof_pend_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      wr_sof_q     <= 1'b0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      vs_q         <= cam_vsync;
      hr_q         <= cam_href;
      dat_q        <= cam_data;
      vs_prev_q    <= vs_q;
      hr_prev_q    <= hr_eff;
      phase_q      <= phase_d;
      byte_q       <= byte_d;
      state_q      <= state_d;
      skip_q       <= skip_d;
      pix_q        <= pix_d;
      line_q       <= line_d;
      slot_q       <= slot_d;
      acc_q        <= acc_d;
      sof_pend_q   <= sof_pend_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      wr_sof_q     <= wr_sof_d;
      frame_done_q <= frame_done_d;
      line_err_q   <= line_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_data    = wr_data_q;
  assign wr_sof     = wr_sof_q;
  assign frame_done = frame_done_q;
  assign line_err   = line_err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Bench for cam_pixel_packer: three instances (plain, skipping, short-geometry byte-swapped)
// share one DVP stream; expected words are queued as frames are driven.
module tb_cam_pixel_packer;

  typedef struct {
    logic [63:0] data;
    logic        sof;
  } exp_t;

  typedef struct {
    int         lines;
    int         ppl;
    int         base;
    logic [2:0] en;
    logic [2:0] cap;
    logic [2:0] err;
    int         cnt_a;
    int         cnt_b;
    int         cnt_c;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  en;
  logic        cam_vsync, cam_href;
  logic [7:0]  cam_data;
  logic        wr_en_v   [3];
  logic [63:0] wr_data_v [3];
  logic        wr_sof_v  [3];
  logic        fd_v      [3];
  logic        le_v      [3];
  logic [15:0] fc_v      [3];

  int   h_of    [3] = '{8, 8, 6};
  int   v_of    [3] = '{2, 2, 1};
  bit   swap_of [3] = '{1'b0, 1'b0, 1'b1};
  exp_t q [3][$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cam_pixel_packer #(.DATA_W(64), .H_ACT(8), .V_ACT(2), .SKIP_FRAMES(0), .BYTE_SWAP(0)) u_dut_a (
    .clk(clk), .rst(rst), .en(en[0]), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .wr_en(wr_en_v[0]), .wr_data(wr_data_v[0]), .wr_sof(wr_sof_v[0]),
    .frame_done(fd_v[0]), .line_err(le_v[0]), .frame_cnt(fc_v[0])
  );

  cam_pixel_packer #(.DATA_W(64), .H_ACT(8), .V_ACT(2), .SKIP_FRAMES(2), .BYTE_SWAP(0)) u_dut_b (
    .clk(clk), .rst(rst), .en(en[1]), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .wr_en(wr_en_v[1]), .wr_data(wr_data_v[1]), .wr_sof(wr_sof_v[1]),
    .frame_done(fd_v[1]), .line_err(le_v[1]), .frame_cnt(fc_v[1])
  );

  cam_pixel_packer #(.DATA_W(64), .H_ACT(6), .V_ACT(1), .SKIP_FRAMES(0), .BYTE_SWAP(1)) u_dut_c (
    .clk(clk), .rst(rst), .en(en[2]), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .wr_en(wr_en_v[2]), .wr_data(wr_data_v[2]), .wr_sof(wr_sof_v[2]),
    .frame_done(fd_v[2]), .line_err(le_v[2]), .frame_cnt(fc_v[2])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest queued word for that instance
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (wr_en_v[d] === 1'b1) begin
        if (q[d].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word[%0d]: got %h, required no write", d, wr_data_v[d]);
        end else begin
          e = q[d].pop_front();
          check($sformatf("word[%0d]", d), wr_data_v[d], e.data);
          check($sformatf("sof[%0d]", d), 64'(wr_sof_v[d]), 64'(e.sof));
        end
      end
    end
  end

  task automatic push_frame(input int d, input int lines, input int ppl, input int base,
                            output bit partial);
    logic [63:0] acc;
    logic [7:0]  b0, b1;
    logic [15:0] pix;
    int          slot;
    bit          first;
    exp_t        e;
    acc   = '0;
    slot  = 0;
    first = 1'b1;
    for (int l = 0; l < lines; l++) begin
      if (l < v_of[d]) begin
        for (int p = 0; p < ppl && p < h_of[d]; p++) begin
          b0  = 8'(base + l * 2 * ppl + 2 * p);
          b1  = 8'(base + l * 2 * ppl + 2 * p + 1);
          pix = swap_of[d] ? {b1, b0} : {b0, b1};
          acc = acc | (64'(pix) << (16 * slot));
          slot++;
          if (slot == 4) begin
            e.data = acc;
            e.sof  = first;
            q[d].push_back(e);
            first = 1'b0;
            acc   = '0;
            slot  = 0;
          end
        end
      end
    end
    if (slot != 0) begin
      e.data = acc;
      e.sof  = first;
      q[d].push_back(e);
    end
    partial = (slot != 0);
  endtask

  task automatic drive_line(input int ppl, input int b);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2 * ppl; k++) begin
      @(negedge clk);
      cam_href = 1'b1;
      cam_data = 8'(b + k);
    end
    @(negedge clk);
    cam_href = 1'b0;
    cam_data = 8'h00;
  endtask

  task automatic drive_body(input int lines, input int ppl, input int base);
    for (int l = 0; l < lines; l++) drive_line(ppl, base + l * 2 * ppl);
  endtask

  // vsync rise; frame_done (and any flush word) must land on the second edge after it is seen
  task automatic vsync_pulse(input logic [2:0] fd_exp, input logic [2:0] fl_exp);
    @(negedge clk);
    cam_vsync = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check($sformatf("frame_done_early[%0d]", d), 64'(fd_v[d]), 64'd0);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("frame_done[%0d]", d), 64'(fd_v[d]), 64'(fd_exp[d]));
      check($sformatf("flush_wr_en[%0d]", d), 64'(wr_en_v[d]), 64'(fl_exp[d]));
    end
    cam_href = 1'b1;
    cam_data = 8'hEE;
    repeat (2) @(negedge clk);
    cam_href = 1'b0;
    @(negedge clk);
    cam_vsync = 1'b0;
  endtask

  task automatic check_state(input string tag, input int c0, input int c1, input int c2,
                             input logic [2:0] err);
    int cexp [3];
    cexp = '{c0, c1, c2};
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s frame_cnt[%0d]", tag, d), 64'(fc_v[d]), 64'(cexp[d]));
      check($sformatf("%s line_err[%0d]", tag, d), 64'(le_v[d]), 64'(err[d]));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s wr_en[%0d]", tag, d), 64'(wr_en_v[d]), 64'd0);
      check($sformatf("%s wr_data[%0d]", tag, d), wr_data_v[d], 64'd0);
      check($sformatf("%s wr_sof[%0d]", tag, d), 64'(wr_sof_v[d]), 64'd0);
      check($sformatf("%s frame_done[%0d]", tag, d), 64'(fd_v[d]), 64'd0);
      check($sformatf("%s line_err[%0d]", tag, d), 64'(le_v[d]), 64'd0);
      check($sformatf("%s frame_cnt[%0d]", tag, d), 64'(fc_v[d]), 64'd0);
    end
  endtask

  initial begin
    vec_t       vec [6];
    bit         p;
    logic [2:0] fl;

    // A captures from the first frame, B skips two, C is enabled later for its 6x1 geometry
    vec[0] = '{2, 8, 'h00, 3'b011, 3'b001, 3'b000, 1, 0, 0};
    vec[1] = '{2, 8, 'h40, 3'b011, 3'b001, 3'b000, 2, 0, 0};
    vec[2] = '{2, 8, 'h80, 3'b011, 3'b011, 3'b000, 3, 1, 0};
    vec[3] = '{2, 7, 'h10, 3'b111, 3'b011, 3'b011, 4, 2, 0};
    vec[4] = '{1, 6, 'h20, 3'b111, 3'b111, 3'b011, 5, 3, 1};
    vec[5] = '{2, 8, 'h60, 3'b111, 3'b111, 3'b111, 6, 4, 2};

    rst       = 1'b1;
    en        = 3'b000;
    cam_vsync = 1'b0;
    cam_href  = 1'b0;
    cam_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    en  = 3'b011;
    vsync_pulse(3'b000, 3'b000);

    for (int i = 0; i < 6; i++) begin
      en = vec[i].en;
      fl = 3'b000;
      for (int d = 0; d < 3; d++) begin
        if (vec[i].cap[d]) begin
          push_frame(d, vec[i].lines, vec[i].ppl, vec[i].base, p);
          fl[d] = p;
        end
      end
      drive_body(vec[i].lines, vec[i].ppl, vec[i].base);
      vsync_pulse(vec[i].cap, fl);
      check_state($sformatf("row%0d", i), vec[i].cnt_a, vec[i].cnt_b, vec[i].cnt_c, vec[i].err);
    end

    // Enable drops during line 1: A still finishes the frame, then stays idle
    fl = 3'b000;
    for (int d = 0; d < 3; d++) begin
      push_frame(d, 2, 8, 'h00, p);
      fl[d] = p;
    end
    drive_line(8, 'h00);
    en[0] = 1'b0;
    drive_line(8, 'h10);
    vsync_pulse(3'b111, fl);
    check_state("en_drop", 7, 5, 3, 3'b111);

    fl = 3'b000;
    for (int d = 1; d < 3; d++) begin
      push_frame(d, 2, 8, 'h40, p);
      fl[d] = p;
    end
    drive_body(2, 8, 'h40);
    vsync_pulse(3'b110, fl);
    check_state("after_drop", 7, 6, 4, 3'b111);

    // Reset after three pixels of a frame: partial words vanish, capture waits for a full frame
    repeat (3) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      cam_href = 1'b1;
      cam_data = 8'(8'h70 + k);
    end
    @(negedge clk);
    rst      = 1'b1;
    cam_href = 1'b0;
    @(negedge clk);
    check_zero("mid_rst");
    rst = 1'b0;
    drive_line(8, 'h90);
    vsync_pulse(3'b000, 3'b000);
    check_state("post_rst", 0, 0, 0, 3'b000);

    fl = 3'b000;
    push_frame(2, 2, 8, 'h33, p);
    fl[2] = p;
    drive_body(2, 8, 'h33);
    vsync_pulse(3'b100, fl);
    check_state("restart", 0, 0, 1, 3'b100);

    repeat (4) @(negedge clk);
    for (int d = 0; d < 3; d++) check($sformatf("pending_words[%0d]", d), 64'(q[d].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no end of test, required end within 500000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cam_pixel_packer.md
# cam_pixel_packer

Single-clock camera front end that turns the sensor's 8-bit DVP byte stream (vsync, href, data) into DDR-width write words for the frame-buffer write FIFO. It is the parametrised successor of the fixed 256-bit capture stage. It adds:
- configurable word width and frame geometry
- start-up frame skipping
- per-line length checking
- end-of-frame flush of partial words
- frame start/done markers and a frame counter

It sits in the cmos_pclk domain between the sensor pins and the FIFO write port.

## Interface
- DATA_W, 256: output word width; multiple of 16, at least 32; PPW = DATA_W/16 pixels per word.
- H_ACT, 1024: active pixels per line.
- V_ACT, 768: active lines per frame.
- SKIP_FRAMES, 2: whole frames discarded after each enable; 0 to 15.
- BYTE_SWAP, 0: 0 means the first byte is pixel[15:8]; 1 means the first byte is pixel[7:0].

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sensor pixel clock (cmos_pclk).
- rst  in  1  synchronous, active-high reset.
- en  in  1  capture enable (ddr init done AND sensor config done).
- cam_vsync  in  1  high during vertical blanking.
- cam_href  in  1  high while line bytes are valid.
- cam_data  in  8  sensor data.
- wr_en  out  1  one-cycle FIFO write strobe.
- wr_data  out  DATA_W  packed pixels; pixel 0 is in [15:0], pixel PPW-1 is in the top 16 bits.
- wr_sof  out  1  high with the first wr_en of a frame.
- frame_done  out  1  one-cycle pulse at end of each captured frame.
- line_err  out  1  sticky flag: a line length differed from H_ACT, or line count differed from V_ACT.
- frame_cnt  out  16  number of captured frames; wraps at 65535 to 0.

## Operation
- The vsync, href and data inputs pass through one register stage; all edge detection uses the registered copies.
- vs_rise marks the frame boundary.
- FSM states: IDLE, SYNC, SKIP, ACTIVE.
  - IDLE: drives nothing. en=1 goes to SYNC.
  - SYNC: vs_rise goes to SKIP if SKIP_FRAMES>0, else to ACTIVE.
  - SKIP: counts vs_rise events. The SKIP_FRAMES-th one goes to ACTIVE.
  - ACTIVE: captures pixels while vsync is low. On vs_rise it performs end-of-frame processing, then goes to IDLE if en=0, else stays in ACTIVE.
  - en is sampled only at frame boundaries in ACTIVE. Deasserting en mid-frame still completes that frame.
  - In SYNC or SKIP, en=0 returns to IDLE immediately.
- Byte pairing:
  - The byte phase toggles on each registered href-high cycle and clears to 0 whenever href is low.
  - Phase 0 is the first byte; phase 1 completes the pixel.
  - An odd trailing byte is dropped.
- Pixel and line counting:
  - The pixel counter resets at href rise.
  - Pixels with index ≥ H_ACT are dropped.
  - Lines with index ≥ V_ACT are dropped.
- Packing:
  - Pixels shift into a DATA_W accumulator.
  - When the PPW-th pixel arrives, the word is emitted and the accumulator restarts.
- Line checking:
  - At href fall, if pixel count ≠ H_ACT, set line_err.
  - At vs_rise in ACTIVE, if line count ≠ V_ACT, set line_err.
- End-of-frame processing (at vs_rise in ACTIVE):
  - If a partial word is pending, emit it with unfilled pixel slots = 0.
  - Pulse frame_done.
  - Increment frame_cnt.
  - Clear the line counter, pixel counter and accumulator.
- wr_sof is set with the first emitted word after entering or re-entering a frame. A single-word frame has wr_sof and frame_done together.

## Timing
- Values after rst: all outputs 0, FSM in IDLE, all counters 0.
- Latency: wr_en goes high 2 clk edges after the edge on which the completing byte is on cam_data (input register plus output register).
- Flush timing:
  - The flush word and frame_done appear 2 edges after the edge on which cam_vsync is first seen high.
  - With no partial word pending, frame_done alone appears at that time.
- wr_en is never high on two consecutive cycles from a flush. Normal words are spaced at least 2·PPW cycles apart.
- wr_data is valid only while wr_en is high. It holds its value otherwise.
- href high while vsync is high is ignored in every state.
- rst mid-frame:
  - Discards the partial word.
  - Clears line_err and frame_cnt.
  - Returns to IDLE; a fresh SYNC and SKIP sequence then follows.

## Test plan
- Basic pack. Stimulus: DATA_W=64, H_ACT=8, V_ACT=2, SKIP_FRAMES=0, BYTE_SWAP=0. Send bytes 0x00..0x1F over 2 lines. Required response:
  - 4 words: the first is 0x0607_0405_0203_0001.
  - wr_sof on word 0.
  - frame_done 2 cycles after vsync rise; frame_cnt=1; line_err=0.
- Skip. Stimulus: SKIP_FRAMES=2, en=1 before 4 frames. Required response: exactly 2 frames produce words; frame_cnt=2.
- Partial flush. Stimulus: H_ACT=6, V_ACT=1, PPW=4. Required response:
  - Word 0 carries pixels 0–3.
  - Word 1 is emitted at vsync rise with bits [63:32]=0 and frame_done in the same cycle.
- Short line. Stimulus: a line of 7 pixels with H_ACT=8. Required response: line_err=1 after href fall; it stays 1 through later good frames until rst.
- Enable drop mid-frame. Stimulus: en falls during line 1. Required response: the frame completes with all 4 words and frame_done; the FSM is IDLE afterwards and the next frame produces nothing.
- Reset mid-frame. Stimulus: rst after 3 pixels. Required response:
  - No wr_en and all outputs 0 on the next cycle.
  - After rst release, capture restarts only at the next full frame.
